shiftreg_word_sequencer: RTL and testbench

- Control stage directly upstream of the 16-bit left-shifting LPM shift register; it owns that register's Data/Load/Enable/ShiftIn pins.
- Accepts parallel words over a valid/ready handshake and loads each one into the shift register.
- Clocks the word out MSB-first, presenting the register's ShiftOut as a qualified serial stream, then pulses Done.
- Gives downstream serial consumers a framed bit stream.

---
 rtl/shiftreg_word_sequencer.sv | 151 +++++++++++++++
 tb/tb_shiftreg_word_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_word_sequencer.sv
// Word sequencer for a left-shifting LPM shift register: accepts parallel
// words over valid/ready, loads each into the register, then clocks it out
// MSB-first as a qualified serial stream followed by a one-cycle Done pulse.
module shiftreg_word_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned GAP   = 0
) (
  input  logic             Clock,
  input  logic             Aclr,
  input  logic [WIDTH-1:0] WordIn,
  input  logic             WordValid,
  output logic             WordReady,
  input  logic             Abort,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] Data,
  output logic             Load,
  output logic             Enable,
  output logic             ShiftIn,
  input  logic             RegShiftOut,
  output logic             SerialOut,
  output logic             SerialValid,
  output logic             Done,
  output logic [CNT_W-1:0] BitCount
);

  localparam int unsigned      GAP_W    = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   hold;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               done_q;
  logic               ready_q;
  logic               load_q;
  logic               enable_q;
  logic               valid_q;

  // Sequencer FSM; every control output is a flop updated with the state.
  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      state    <= ST_IDLE;
      hold     <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Abort wins over an accept at the same edge.
          if (WordValid && !Abort) begin
            hold     <= WordIn;
            state    <= ST_LOAD;
            ready_q  <= 1'b0;
            load_q   <= 1'b1;
            enable_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (Abort) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
          end else begin
            state   <= ST_SHIFT;
            load_q  <= 1'b0;
            valid_q <= 1'b1;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (Abort) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
          end else if (bit_cnt == LAST_BIT) begin
            done_q   <= 1'b1;
            bit_cnt  <= '0;
            valid_q  <= 1'b0;
            enable_q <= 1'b0;
            gap_cnt  <= '0;
            if (GAP > 0) begin
              state <= ST_GAP;
            end else begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (Abort || (gap_cnt == LAST_GAP)) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          ready_q  <= 1'b1;
          load_q   <= 1'b0;
          enable_q <= 1'b0;
          valid_q  <= 1'b0;
          bit_cnt  <= '0;
          gap_cnt  <= '0;
        end
      endcase
    end
  end

  // Register-facing pins and the qualified serial stream.
  assign WordReady   = ready_q;
  assign Load        = load_q;
  assign Enable      = enable_q;
  assign Data        = hold;
  assign BitCount    = bit_cnt;
  assign Done        = done_q;
  assign SerialValid = valid_q;
  assign SerialOut   = valid_q & RegShiftOut;
  assign ShiftIn     = valid_q & SerialIn;

endmodule

// File: tb/tb_shiftreg_word_sequencer.sv
// Bench for shiftreg_word_sequencer: two instances (GAP=0 and GAP=3) share
// stimulus, each drives its own behavioural lpm_shiftreg, and a
// position-in-word model predicts every output on every cycle.
module tb_shiftreg_word_sequencer;

  localparam int W  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr       = 1'b0;
  logic [W-1:0]  word_in    = '0;
  logic          word_valid = 1'b0;
  logic          abort      = 1'b0;
  logic          serial_in  = 1'b0;

  logic          word_ready   [2];
  logic          load         [2];
  logic          enable       [2];
  logic          shift_in     [2];
  logic          reg_so       [2];
  logic          serial_out   [2];
  logic          serial_valid [2];
  logic          done         [2];
  logic [W-1:0]  data         [2];
  logic [CW-1:0] bit_count    [2];
  logic [W-1:0]  q            [2] = '{16'h0, 16'h0};

  shiftreg_word_sequencer #(.WIDTH(W), .CNT_W(CW), .GAP(0)) u_dut (
    .Clock(clk), .Aclr(aclr), .WordIn(word_in), .WordValid(word_valid),
    .WordReady(word_ready[0]), .Abort(abort), .SerialIn(serial_in),
    .Data(data[0]), .Load(load[0]), .Enable(enable[0]), .ShiftIn(shift_in[0]),
    .RegShiftOut(reg_so[0]), .SerialOut(serial_out[0]),
    .SerialValid(serial_valid[0]), .Done(done[0]), .BitCount(bit_count[0])
  );

  shiftreg_word_sequencer #(.WIDTH(W), .CNT_W(CW), .GAP(3)) u_dut_gap3 (
    .Clock(clk), .Aclr(aclr), .WordIn(word_in), .WordValid(word_valid),
    .WordReady(word_ready[1]), .Abort(abort), .SerialIn(serial_in),
    .Data(data[1]), .Load(load[1]), .Enable(enable[1]), .ShiftIn(shift_in[1]),
    .RegShiftOut(reg_so[1]), .SerialOut(serial_out[1]),
    .SerialValid(serial_valid[1]), .Done(done[1]), .BitCount(bit_count[1])
  );

  // Behavioural lpm_shiftreg (left shift, ShiftOut = Q[W-1]), one per instance.
  assign reg_so[0] = q[0][W-1];
  assign reg_so[1] = q[1][W-1];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (enable[i]) q[i] <= load[i] ? data[i] : {q[i][W-2:0], shift_in[i]};
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Model: pos counts cycles since accept (1 = load, 2..W+1 = bits, then gap).
  bit           m_busy [2] = '{1'b0, 1'b0};
  int           m_pos  [2] = '{0, 0};
  logic [W-1:0] m_word [2] = '{16'h0, 16'h0};
  logic [W-1:0] m_hold [2] = '{16'h0, 16'h0};
  bit           m_done [2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge aclr) begin
    for (int i = 0; i < 2; i++) begin
      if (aclr) begin
        m_busy[i] <= 1'b0;
        m_pos[i]  <= 0;
        m_hold[i] <= '0;
        m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (word_valid && !abort) begin
            m_busy[i] <= 1'b1;
            m_pos[i]  <= 1;
            m_word[i] <= word_in;
            m_hold[i] <= word_in;
          end
        end else if (abort) begin
          m_busy[i] <= 1'b0;
        end else begin
          m_pos[i]  <= m_pos[i] + 1;
          m_done[i] <= (m_pos[i] + 1 == W + 2);
          m_busy[i] <= !(m_pos[i] + 1 >= W + 2 + gap_of(i));
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  bit            started = 1'b0;
  logic          e_sv;
  logic          e_so;
  logic [CW-1:0] e_bc;
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        e_sv = m_busy[i] && (m_pos[i] >= 2) && (m_pos[i] <= W + 1);
        e_so = e_sv ? m_word[i][W + 1 - m_pos[i]] : 1'b0;
        e_bc = e_sv ? CW'(m_pos[i] - 2) : '0;
        check($sformatf("i%0d.WordReady", i), 32'(word_ready[i]), 32'(!m_busy[i]));
        check($sformatf("i%0d.Load", i), 32'(load[i]), 32'(m_busy[i] && m_pos[i] == 1));
        check($sformatf("i%0d.Enable", i), 32'(enable[i]),
              32'(m_busy[i] && m_pos[i] >= 1 && m_pos[i] <= W + 1));
        check($sformatf("i%0d.ShiftIn", i), 32'(shift_in[i]), 32'(e_sv & serial_in));
        check($sformatf("i%0d.SerialValid", i), 32'(serial_valid[i]), 32'(e_sv));
        check($sformatf("i%0d.SerialOut", i), 32'(serial_out[i]), 32'(e_so));
        check($sformatf("i%0d.BitCount", i), 32'(bit_count[i]), 32'(e_bc));
        check($sformatf("i%0d.Done", i), 32'(done[i]), 32'(m_done[i]));
        check($sformatf("i%0d.Data", i), 32'(data[i]), 32'(m_hold[i]));
      end
    end
  end

  // Serial stream and Done collectors for literal end-of-test expectations.
  logic [63:0] s0 = '0;
  int          n0 = 0;
  int          d0 = 0;
  int          d1 = 0;
  always @(negedge clk) begin
    if (!aclr) begin
      if (serial_valid[0]) begin
        s0 <= {s0[62:0], serial_out[0]};
        n0 <= n0 + 1;
      end
      if (done[0]) d0 <= d0 + 1;
      if (done[1]) d1 <= d1 + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (word_ready[0] && word_ready[1]) break;
      step();
    end
    check("wait_idle", 32'(word_ready[0] & word_ready[1]), 32'd1);
  endtask

  logic [W-1:0] ref_word;
  int           dsum;

  initial begin
    // Reset values
    #1 aclr = 1'b1;
    #1 started = 1'b1;
    check("rst.WordReady", 32'(word_ready[0]), 32'd1);
    check("rst.Data", 32'(data[0]), 32'd0);
    check("rst.Enable", 32'(enable[0]), 32'd0);
    check("rst.SerialValid", 32'(serial_valid[0]), 32'd0);
    check("rst.BitCount", 32'(bit_count[0]), 32'd0);
    step();
    step();
    aclr = 1'b0;
    step();

    // Single word A5C3: load in cycle 1, bits in 2..17, Done in 18
    ref_word = 16'hA5C3;
    word_in = ref_word; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("single.Load", 32'(load[0]), 32'd1);
    check("single.Data", 32'(data[0]), 32'hA5C3);
    check("single.WordReady", 32'(word_ready[0]), 32'd0);
    for (int k = 0; k < W; k++) begin
      step();
      check($sformatf("single.valid%0d", k), 32'(serial_valid[0]), 32'd1);
      check($sformatf("single.bit%0d", k), 32'(serial_out[0]), 32'(ref_word[W-1-k]));
      check($sformatf("single.BitCount%0d", k), 32'(bit_count[0]), 32'(k));
    end
    step();
    check("single.Done18", 32'(done[0]), 32'd1);
    check("single.Ready18", 32'(word_ready[0]), 32'd1);
    check("single.g3Ready18", 32'(word_ready[1]), 32'd0);
    step();
    check("single.Done19", 32'(done[0]), 32'd0);
    wait_idle();

    // Back-to-back with valid held high
    s0 = '0; n0 = 0; dsum = d0;
    word_in = 16'hFFFF; word_valid = 1'b1;
    step();
    word_in = 16'h0001;
    repeat (17) step();
    check("b2b.Done18", 32'(done[0]), 32'd1);
    check("b2b.Ready18", 32'(word_ready[0]), 32'd1);
    step();
    check("b2b.Load19", 32'(load[0]), 32'd1);
    check("b2b.Data19", 32'(data[0]), 32'h0001);
    repeat (3) step();
    word_valid = 1'b0;
    repeat (30) step();
    wait_idle();
    check("b2b.nbits", 32'(n0), 32'd32);
    check("b2b.stream", s0[31:0], 32'hFFFF0001);
    check("b2b.ndone", 32'(d0 - dsum), 32'd2);

    // GAP=3 timing with 8000
    word_in = 16'h8000; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (17) step();
    check("gap.Done18", 32'(done[1]), 32'd1);
    check("gap.Ready18", 32'(word_ready[1]), 32'd0);
    step();
    check("gap.Ready19", 32'(word_ready[1]), 32'd0);
    step();
    check("gap.Ready20", 32'(word_ready[1]), 32'd0);
    step();
    check("gap.Ready21", 32'(word_ready[1]), 32'd1);
    check("gap.Done21", 32'(done[1]), 32'd0);
    wait_idle();

    // Abort at BitCount=4, then 1234 goes through intact
    word_in = 16'hBEEF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (5) step();
    check("abort.BitCount4", 32'(bit_count[0]), 32'd4);
    dsum = d0 + d1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.Ready", 32'(word_ready[0]), 32'd1);
    check("abort.BitCount", 32'(bit_count[0]), 32'd0);
    check("abort.SerialValid", 32'(serial_valid[0]), 32'd0);
    repeat (25) step();
    check("abort.noDone", 32'(d0 + d1), 32'(dsum));
    s0 = '0; n0 = 0;
    word_in = 16'h1234; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (20) step();
    wait_idle();
    check("abort.nbits", 32'(n0), 32'd16);
    check("abort.next", 32'(s0[15:0]), 32'h1234);

    // Fill path: SerialIn=1 while shifting zeros
    serial_in = 1'b1;
    word_in = 16'h0000; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (17) step();
    check("fill.Q0", 32'(q[0]), 32'hFFFF);
    check("fill.Q1", 32'(q[1]), 32'hFFFF);
    serial_in = 1'b0;
    wait_idle();

    // Aclr mid-SHIFT at BitCount=7
    word_in = 16'h5A5A; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (8) step();
    check("aclr.BitCount7", 32'(bit_count[0]), 32'd7);
    dsum = d0 + d1;
    #1 aclr = 1'b1;
    #1;
    check("aclr.SerialValid", 32'(serial_valid[0]), 32'd0);
    check("aclr.Enable", 32'(enable[0]), 32'd0);
    check("aclr.WordReady", 32'(word_ready[0]), 32'd1);
    check("aclr.BitCount", 32'(bit_count[0]), 32'd0);
    step();
    step();
    aclr = 1'b0;
    repeat (25) step();
    check("aclr.noDone", 32'(d0 + d1), 32'(dsum));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
